// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- HI/LO unit for the execute stage.
//
// Sequences MULT/MULTU (fixed latency) and DIV/DIVU (radix-2 restoring,
// one quotient bit per clock) and owns the architectural HI/LO registers,
// which MTHI/MTLO also write while the unit is idle.
//
// Ports:
//   clk     in   clock
//   resetn  in   synchronous reset, active-low
//   valid   in   operation request (sampled in IDLE only)
//   funct   in   4'b1011 MULT, 4'b1100 MULTU, 4'b1101 DIV, 4'b1110 DIVU
//   a, b    in   rs / rt operands
//   hi_we   in   MTHI write (idle only)
//   lo_we   in   MTLO write (idle only)
//   wdata   in   MTHI/MTLO data
//   flush   in   abort in-flight operation
//   busy    out  operation in flight
//   done    out  one-cycle pulse, HI/LO just updated by an operation
//   hi, lo  out  HI / LO registers
//
// Latency: the accept edge counts as edge 1 of MUL_LAT, so a multiply
// holds busy for MUL_LAT-1 cycles (MUL_LAT=1 writes HI/LO on the accept
// edge itself). A divide spends 32 edges producing quotient bits and one
// more edge on sign fixup, so done follows 33 edges after the accept edge.
module muldiv_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [3:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    localparam logic [5:0] MUL_LAST = (MUL_LAT >= 2) ? 6'(MUL_LAT - 2) : 6'd0;
    localparam logic [5:0] DIV_LAST = 6'd32;

    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_a, r_b;
    logic        r_sgn;
    logic [63:0] r_rem;      // {remainder, quotient} shift register
    logic [31:0] r_dvs;      // divisor magnitude
    logic        r_neg_q, r_neg_r, r_dz;
    logic [31:0] r_hi, r_lo;
    logic        r_done;

    logic        w_legal, w_is_mul, w_signed, w_accept;
    logic        w_mul_fin, w_div_fin;
    logic [31:0] w_ma, w_mb;
    logic        w_msg;
    logic [65:0] w_prod_full;
    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_sh33, w_diff;
    logic        w_ge;
    logic [63:0] w_rem_nxt;
    logic [31:0] w_q, w_r, w_div_lo, w_div_hi;

    assign w_legal  = (funct == 4'b1011) || (funct == 4'b1100) ||
                      (funct == 4'b1101) || (funct == 4'b1110);
    assign w_is_mul = (funct == 4'b1011) || (funct == 4'b1100);
    assign w_signed = (funct == 4'b1011) || (funct == 4'b1101);
    // flush in IDLE blocks acceptance of a same-cycle request
    assign w_accept = (r_state == S_IDLE) && valid && w_legal && !flush;

    // Multiplier takes live inputs in IDLE so MUL_LAT=1 can finish on the
    // accept edge; otherwise it sees the latched operands.
    assign w_ma  = (r_state == S_IDLE) ? a : r_a;
    assign w_mb  = (r_state == S_IDLE) ? b : r_b;
    assign w_msg = (r_state == S_IDLE) ? w_signed : r_sgn;
    assign w_prod_full = 66'($signed({w_msg & w_ma[31], w_ma}) *
                             $signed({w_msg & w_mb[31], w_mb}));

    assign w_abs_a = (w_signed && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b = (w_signed && b[31]) ? (32'd0 - b) : b;

    // Restoring step: shift the pair left one, trial-subtract the divisor
    // from the upper 33 bits (bit 63 may be set before the shift).
    assign w_sh33    = r_rem[63:31];
    assign w_diff    = w_sh33 - {1'b0, r_dvs};
    assign w_ge      = (w_sh33 >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? {w_diff[31:0], r_rem[30:0], 1'b1}
                            : {r_rem[62:0], 1'b0};

    assign w_q      = r_rem[31:0];
    assign w_r      = r_rem[63:32];
    assign w_div_lo = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - w_q) : w_q);
    assign w_div_hi = r_dz ? r_a           : (r_neg_r ? (32'd0 - w_r) : w_r);

    always_comb begin
        w_next    = r_state;
        w_mul_fin = 1'b0;
        w_div_fin = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        if (MUL_LAT <= 1) w_mul_fin = 1'b1;
                        else              w_next    = S_MUL;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == MUL_LAST) begin
                    w_mul_fin = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == DIV_LAST) begin
                    w_div_fin = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt   <= 6'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_sgn   <= 1'b0;
            r_rem   <= 64'd0;
            r_dvs   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_mul_fin | w_div_fin;

            if (w_accept)                r_cnt <= 6'd0;
            else if (r_state != S_IDLE)  r_cnt <= r_cnt + 6'd1;

            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_sgn   <= w_signed;
                r_rem   <= {32'd0, w_abs_a};
                r_dvs   <= w_abs_b;
                r_neg_q <= w_signed & (a[31] ^ b[31]);
                r_neg_r <= w_signed & a[31];
                r_dz    <= (b == 32'd0);
            end else if (r_state == S_DIV && !flush && r_cnt < DIV_LAST) begin
                r_rem <= w_rem_nxt;
            end

            // MTHI/MTLO first; an operation finishing on the same edge wins
            if (r_state == S_IDLE) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
            if (w_mul_fin) begin
                r_hi <= w_prod_full[63:32];
                r_lo <= w_prod_full[31:0];
            end
            if (w_div_fin) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 3;
    localparam int ML = MUL_LAT - 1;   // busy cycles for a multiply
    localparam int DL = 33;            // busy cycles for a divide

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  funct = 4'd0;
    logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
    logic        hi_we = 1'b0, lo_we = 1'b0, flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int nchk = 0;
    int nerr = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .funct(funct),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a, b, eh, el;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Issue one op (optionally with a same-cycle MTHI), wait for done,
    // check latency, HI, LO and that done is a single pulse.
    task automatic run_op(input string nm, input logic [3:0] f, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] eh, input logic [31:0] el,
                          input int lat, input logic with_we, input logic [31:0] wd);
        int cnt = 0;
        int guard = 0;
        @(negedge clk);
        valid = 1'b1; funct = f; a = aa; b = bb;
        hi_we = with_we; wdata = wd;
        @(negedge clk);
        valid = 1'b0; hi_we = 1'b0;
        while (!done && guard < 100) begin
            if (busy) cnt++;
            @(negedge clk);
            guard++;
        end
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " busy_cycles"}, cnt, lat);
        chk({nm, " busy_with_done"}, 32'(busy), 32'd0);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b1011, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, ML};
        vecs[1] = '{4'b1100, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, ML};
        vecs[2] = '{4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, ML};
        vecs[3] = '{4'b1011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, ML};
        vecs[4] = '{4'b1110, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, DL};
        vecs[5] = '{4'b1101, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DL};
        vecs[6] = '{4'b1101, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DL};
        vecs[7] = '{4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DL};
        vecs[8] = '{4'b1110, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, DL};
        vecs[9] = '{4'b1110, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999, DL};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        resetn = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].eh, vecs[i].el, vecs[i].lat, 1'b0, 32'd0);

        // signed divide by zero keeps the original (negative) dividend in HI
        run_op("div_by_zero_signed", 4'b1101, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, DL, 1'b0, 32'd0);

        // MTHI / MTLO in idle
        @(negedge clk); hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk); hi_we = 1'b0;
        chk("mthi hi", hi, 32'hDEAD_BEEF);
        chk("mthi done", 32'(done), 32'd0);

        // illegal funct is ignored
        valid = 1'b1; funct = 4'b0000;
        @(negedge clk); valid = 1'b0;
        chk("illegal busy", 32'(busy), 32'd0);

        // flush in IDLE blocks a same-cycle valid
        valid = 1'b1; funct = 4'b1110; a = 32'd9; b = 32'd3; flush = 1'b1;
        @(negedge clk); valid = 1'b0; flush = 1'b0;
        chk("idle_flush busy", 32'(busy), 32'd0);

        // flush mid-divide, with a stray valid and an MTHI while busy
        hi_we = 1'b1; lo_we = 1'b0; wdata = 32'hAAAA_0000;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5555;
        @(negedge clk); lo_we = 1'b0;
        valid = 1'b1; funct = 4'b1101; a = 32'd100; b = 32'd7;
        @(negedge clk); valid = 1'b0;           // accept edge E0 passed
        repeat (2) @(negedge clk);
        valid = 1'b1; funct = 4'b1101; a = 32'd1; b = 32'd1;
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk); valid = 1'b0; hi_we = 1'b0;
        chk("busy_we hi", hi, 32'hAAAA_0000);
        repeat (6) @(negedge clk);
        flush = 1'b1;                           // seen at edge E10
        @(negedge clk); flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush done", 32'(done), 32'd0);
        begin
            int seen = 0;
            repeat (40) begin
                if (busy || done) seen++;
                @(negedge clk);
            end
            chk("flush no_activity", seen, 0);
        end
        chk("flush hi", hi, 32'hAAAA_0000);
        chk("flush lo", lo, 32'h0000_5555);

        // reset mid-divide
        valid = 1'b1; funct = 4'b1110; a = 32'd1000; b = 32'd3;
        @(negedge clk); valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        resetn = 1'b1;
        run_op("after_reset", 4'b1100, 32'd7, 32'd6, 32'd0, 32'd42, ML, 1'b0, 32'd0);

        // MULTU with MTHI on the accept edge: result overwrites HI
        run_op("mul_with_mthi", 4'b1100, 32'd2, 32'd3, 32'd0, 32'd6, ML, 1'b1, 32'hFFFF_0000);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
